// File: rtl/if_prefetch.sv
// Instruction-fetch initiator: drives the combinational ROM port and buffers
// fetched {pc, inst} pairs in a small circular prefetch queue for IF/ID.
module if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic             en_q;
  logic [31:0]      fetch_pc;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;
  logic             redirect;

  always_comb begin
    if_valid_o = (count != '0);
    pop        = if_valid_o & ~stall_i & ~branch_flag_i;
    // A full queue may still fetch when the head leaves in the same cycle.
    push       = en_q & ~branch_flag_i & ((count < FULL) | pop);
    redirect   = branch_flag_i & en_q;
    rom_ce_o   = push;
    rom_addr_o = fetch_pc;
    if_pc_o    = if_valid_o ? pc_mem[rd_ptr]   : '0;
    if_inst_o  = if_valid_o ? inst_mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      en_q <= 1'b1;
      if (redirect) begin
        fetch_pc <= {branch_target_i[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr]   <= fetch_pc;
          inst_mem[wr_ptr] <= rom_inst_i;
          wr_ptr           <= wr_ptr + PTR_W'(1);
          fetch_pc         <= fetch_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: queue-based reference model plus an
// in-order acceptance scoreboard, directed scenarios and random stalls.
module tb_if_prefetch;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_inst_i(rom_inst_i),
    .stall_i(stall_i), .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign rom_inst_i = rom_word(rom_addr_o);

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        q[$];
  bit          m_en, m_init;
  logic [31:0] m_fpc, exp_acc;
  int          checks, failures;
  logic        last_ce, last_valid;
  logic [31:0] last_addr, last_pc, last_inst;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t);
    bit          mvalid, mpop, mce;
    logic [31:0] mpc, minst;
    @(negedge clk);
    rst = r; stall_i = s; branch_flag_i = b; branch_target_i = t;
    #1;
    mvalid = (q.size() != 0);
    mpc    = mvalid ? q[0].pc   : 32'h0;
    minst  = mvalid ? q[0].inst : 32'h0;
    mpop   = mvalid && !s && !b;
    mce    = m_en && !b && (q.size() < DEPTH || mpop);
    last_ce = rom_ce_o; last_valid = if_valid_o; last_addr = rom_addr_o;
    last_pc = if_pc_o; last_inst = if_inst_o;
    if (m_init) begin
      check("rom_ce", {31'b0, rom_ce_o}, {31'b0, mce});
      check("rom_addr", rom_addr_o, m_fpc);
      check("if_valid", {31'b0, if_valid_o}, {31'b0, mvalid});
      check("if_pc", if_pc_o, mpc);
      check("if_inst", if_inst_o, minst);
      check("count_max", {31'b0, dut.count <= 3'd4}, 32'd1);
      if (!r && if_valid_o && !s && !b) begin
        check("acc_pc", if_pc_o, exp_acc);
        check("acc_inst", if_inst_o, rom_word(exp_acc));
        exp_acc = exp_acc + 32'd4;
      end
    end
    if (r) begin
      m_en = 1'b0; m_fpc = RESET_PC; q.delete(); exp_acc = RESET_PC; m_init = 1'b1;
    end else begin
      if (b && m_en) begin
        q.delete();
        m_fpc = {t[31:2], 2'b00};
        exp_acc = m_fpc;
      end else begin
        if (mpop) q.delete(0);
        if (mce) begin
          q.push_back('{pc: m_fpc, inst: rom_word(m_fpc)});
          m_fpc = m_fpc + 32'd4;
        end
      end
      m_en = 1'b1;
    end
  endtask

  initial begin
    int          nfetch;
    logic [31:0] wrap_pcs [4];
    wrap_pcs[0] = 32'hFFFF_FFF8; wrap_pcs[1] = 32'hFFFF_FFFC;
    wrap_pcs[2] = 32'h0000_0000; wrap_pcs[3] = 32'h0000_0004;
    checks = 0; failures = 0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_valid", {31'b0, last_valid}, 32'd0);
    check("rst_addr", last_addr, RESET_PC);

    // Reset release, then stall fill from the first valid cycle.
    step(0, 0, 0, 0);
    check("rel_ce0", {31'b0, last_ce}, 32'd0);
    step(0, 0, 0, 0);
    check("rel_ce1", {31'b0, last_ce}, 32'd1);
    check("rel_addr1", last_addr, RESET_PC);
    nfetch = 1;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      nfetch += int'(last_ce);
      check("stall_head", last_pc, 32'h0);
    end
    check("stall_fetches", nfetch, DEPTH);
    check("stall_ce_off", {31'b0, last_ce}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      check("release_valid", {31'b0, last_valid}, 32'd1);
      check("release_pc", last_pc, 32'(4 * i));
    end

    // Branch with a partially full queue and stall asserted.
    step(0, 0, 1, 32'h40);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h0000_0103);
    step(0, 0, 0, 0);
    check("br_valid", {31'b0, last_valid}, 32'd0);
    check("br_addr", last_addr, 32'h0000_0100);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      check("br_pc", last_pc, 32'h100 + 32'(4 * i));
    end

    // Address wrap.
    step(0, 0, 1, 32'hFFFF_FFF8);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      check("wrap_pc", last_pc, wrap_pcs[i]);
    end

    // Reset mid-stream with full queue and a simultaneous branch.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    check("pre_rst_full", {31'b0, last_valid}, 32'd1);
    step(1, 1, 1, 32'h200);
    step(0, 0, 0, 0);
    check("mid_rst_valid", {31'b0, last_valid}, 32'd0);
    check("mid_rst_pc", last_pc, 32'h0);
    check("mid_rst_inst", last_inst, 32'h0);
    check("mid_rst_ce", {31'b0, last_ce}, 32'd0);
    check("mid_rst_addr", last_addr, RESET_PC);
    step(0, 0, 0, 0);
    check("mid_rst_refetch", {31'b0, last_ce}, 32'd1);
    step(0, 0, 0, 0);
    check("mid_rst_head", last_pc, RESET_PC);

    // Random stall pattern with occasional redirects.
    for (int i = 0; i < 1000; i++) begin
      step(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
